// File: rtl/fetch_align.sv
// fetch_align: splits word fetches into RV32/RV32C instrs, two per cycle
// Build option: FETCH_ALIGN_ZERO_ILL_EN traps a 16'h0000 head halfword
module fetch_align #(
  parameter logic [31:0] BootAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_data_i,
  input  logic        fetch_err_i,
  output logic        fetch_rdy_o,
  output logic [1:0]  out_valid_o,
  input  logic [1:0]  out_rdy_i,
  output logic [31:0] out_instr0_o,
  output logic [31:0] out_instr1_o,
  output logic [31:0] out_pc0_o,
  output logic [31:0] out_pc1_o,
  output logic        out_c0_o,
  output logic        out_c1_o,
  output logic        out_err0_o,
  output logic        out_err1_o
);

  typedef enum logic {RUN, HALT} state_e;

  typedef struct packed {
    logic        done;
    logic        err;
    logic        c;
    logic [2:0]  sz;
    logic [31:0] instr;
  } slot_t;

  state_e           fsm_q, fsm_d;
  logic [2:0][15:0] stash_q, stash_d;
  logic [2:0]       serr_q, serr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             skip_q, skip_d;

  logic [3:0][15:0] win;
  logic [3:0]       werr;
  logic [2:0]       wcnt;
  logic             accept;
  slot_t            s0, s1;
  logic             v0, v1, n1, n2, halt;
  logic [2:0]       used;

  // Decode one instruction starting at halfword st of an n-deep window
  function automatic slot_t decode(
    input logic [3:0][15:0] w,
    input logic [3:0]       e,
    input logic [2:0]       st,
    input logic [2:0]       n
  );
    slot_t       r;
    logic [1:0]  i;
    logic [15:0] lo, hi;
    logic        zero;
    r  = '0;
    i  = st[1:0];
    lo = w[i];
    hi = w[i + 2'd1];
`ifdef FETCH_ALIGN_ZERO_ILL_EN
    zero = (lo == 16'h0000);
`else
    zero = 1'b0;
`endif
    if (n > st) begin
      if (e[i]) begin
        r.done = 1'b1;
        r.err  = 1'b1;
        r.sz   = 3'd1;
      end else if (zero) begin
        r.done = 1'b1;
        r.err  = 1'b1;
        r.c    = 1'b1;
        r.sz   = 3'd1;
      end else if (lo[1:0] == 2'b11) begin
        if (n >= st + 3'd2) begin
          r.done  = 1'b1;
          r.err   = e[i + 2'd1];
          r.sz    = 3'd2;
          r.instr = r.err ? 32'd0 : {hi, lo};
        end
      end else begin
        r.done  = 1'b1;
        r.c     = 1'b1;
        r.sz    = 3'd1;
        r.instr = {16'h0000, lo};
      end
    end
    return r;
  endfunction

  assign fetch_rdy_o = (fsm_q == RUN) & (cnt_q <= 2'd1) & ~flush_i;
  assign accept      = fetch_valid_i & fetch_rdy_o;

  // Assemble the window: stashed halfwords, then the accepted word
  always_comb begin
    win  = '0;
    werr = '0;
    wcnt = {1'b0, cnt_q};
    for (int k = 0; k < 3; k++) begin
      win[k]  = stash_q[k];
      werr[k] = serr_q[k];
    end
    if (accept) begin
      if (!skip_q) begin
        win[wcnt[1:0]]  = fetch_data_i[15:0];
        werr[wcnt[1:0]] = fetch_err_i;
        wcnt = wcnt + 3'd1;
      end
      win[wcnt[1:0]]  = fetch_data_i[31:16];
      werr[wcnt[1:0]] = fetch_err_i;
      wcnt = wcnt + 3'd1;
    end
  end

  // Decode both slots and size the consumed part of the window
  always_comb begin
    s0   = decode(win, werr, 3'd0, wcnt);
    s1   = decode(win, werr, s0.sz, wcnt);
    v0   = (fsm_q == RUN) & ~flush_i & s0.done;
    v1   = v0 & ~s0.err & s1.done;
    n2   = v0 & v1 & (out_rdy_i == 2'b11);
    n1   = v0 & out_rdy_i[0] & ~n2;
    used = n2 ? (s0.sz + s1.sz) : (n1 ? s0.sz : 3'd0);
    halt = (n1 & s0.err) | (n2 & (s0.err | s1.err));
  end

  // Drive slot outputs, zeroed when the slot is not valid
  always_comb begin
    out_valid_o  = {v1, v0};
    out_instr0_o = v0 ? s0.instr : 32'd0;
    out_instr1_o = v1 ? s1.instr : 32'd0;
    out_c0_o     = v0 & s0.c;
    out_c1_o     = v1 & s1.c;
    out_err0_o   = v0 & s0.err;
    out_err1_o   = v1 & s1.err;
    out_pc0_o    = v0 ? pc_q : 32'd0;
    out_pc1_o    = v1 ? pc_q + (s0.c ? 32'd2 : 32'd4) : 32'd0;
  end

  // Next state: keep unconsumed halfwords, advance pc, flush wins
  always_comb begin
    logic [3:0][15:0] sh;
    logic [3:0]       she;
    logic [2:0]       left;
    sh      = win >> {used, 4'b0000};
    she     = werr >> used;
    left    = wcnt - used;
    stash_d = sh[2:0];
    serr_d  = she[2:0];
    cnt_d   = left[1:0];
    pc_d    = pc_q + {28'd0, used, 1'b0};
    skip_d  = skip_q & ~accept;
    fsm_d   = halt ? HALT : fsm_q;
    if (flush_i) begin
      cnt_d  = 2'd0;
      pc_d   = {redirect_pc_i[31:1], 1'b0};
      skip_d = redirect_pc_i[1];
      fsm_d  = RUN;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= RUN;
      stash_q <= '0;
      serr_q  <= '0;
      cnt_q   <= 2'd0;
      pc_q    <= {BootAddr[31:1], 1'b0};
      skip_q  <= BootAddr[1];
    end else begin
      fsm_q   <= fsm_d;
      stash_q <= stash_d;
      serr_q  <= serr_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
    end
  end

endmodule
